// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states, source limit.
package int_ctrl_pkg;

    localparam int NSRC_MAX = 8;

    localparam logic [2:0] ADDR_PEND = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_MODE = 3'd4;
    localparam logic [2:0] ADDR_ISR  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index priority encoder: source 0 wins over every other pending source.
module int_prio_enc #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [2:0]      idx
);

    // Scan from the top down so the last hit (lowest index) is the one kept.
    always_comb begin
        valid = |req;
        idx   = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) idx = i[2:0];
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge/level pending capture, mask, single-level request/service FSM
// and a small register file (PEND, MASK, MODE, ISR).
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         NSRC     = 8,
    parameter logic [7:0] MASK_RST = 8'h00
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_n,
    input  logic            intCtrl,
    input  logic            read_enable,
    input  logic            write_enable,
    input  logic [2:0]      address,
    input  logic [15:0]     write_data_in,
    output logic [15:0]     read_data_out,
    output logic            int_req,
    input  logic            int_ack,
    output logic [2:0]      int_vec
);

    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] hist_q, hist_d;
    logic [2:0]      vec_q, vec_d;
    logic [15:0]     rdata_q, rdata_d;
    state_e          state_q, state_d;

    logic            rd_strobe, wr_strobe, ack_take;
    logic            enc_valid;
    logic [2:0]      enc_idx;
    logic [NSRC-1:0] masked, w1c, ack_clr, edge_set;
    logic            unused_wd;

    // Upper write-data bits carry nothing for this block.
    assign unused_wd = ^write_data_in[15:NSRC];

    assign masked = pend_q & mask_q;

    int_prio_enc #(.NSRC(NSRC)) u_prio (
        .req   (masked),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Bus decode: a simultaneous read wins and suppresses the write.
    always_comb begin
        rd_strobe = intCtrl & read_enable;
        wr_strobe = intCtrl & write_enable & ~read_enable;
    end

    // FSM next state: a vanished request falls back to IDLE before an ack can take it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (enc_valid) state_d = ST_REQ;
            ST_REQ:     if (!enc_valid) state_d = ST_IDLE;
                        else if (int_ack) state_d = ST_SERVICE;
            ST_SERVICE: if (wr_strobe && address == ADDR_ISR) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the vector tracks the encoder while requesting, else holds the serviced index.
    always_comb begin
        int_req = (state_q == ST_REQ);
        int_vec = (state_q == ST_REQ) ? enc_idx : vec_q;
    end

    // Pending, mask, mode and vector capture; an edge set beats any clear of the same bit.
    always_comb begin
        ack_take = (state_q == ST_REQ) && enc_valid && int_ack;
        vec_d    = ack_take ? enc_idx : vec_q;
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = ack_take && (enc_idx == i[2:0]) && mode_q[i];
        end
        w1c      = (wr_strobe && address == ADDR_PEND) ? write_data_in[NSRC-1:0] : '0;
        edge_set = mode_q & hist_q & ~irq_n;
        pend_d   = (mode_q & ((pend_q & ~(w1c | ack_clr)) | edge_set)) | (~mode_q & ~irq_n);
        hist_d   = irq_n;
        mask_d   = (wr_strobe && address == ADDR_MASK) ? write_data_in[NSRC-1:0] : mask_q;
        mode_d   = (wr_strobe && address == ADDR_MODE) ? write_data_in[NSRC-1:0] : mode_q;
    end

    // Read mux: registered, updated only on a read strobe; odd addresses read zero.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_strobe) begin
            unique case (address)
                ADDR_PEND: rdata_d = 16'(pend_q);
                ADDR_MASK: rdata_d = 16'(mask_q);
                ADDR_MODE: rdata_d = 16'(mode_q);
                ADDR_ISR:  rdata_d = {state_q == ST_SERVICE, state_q == ST_REQ, 11'd0, int_vec};
                default:   rdata_d = 16'h0000;
            endcase
        end
    end

    // State registers; reset aborts any request or service immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            mask_q  <= MASK_RST[NSRC-1:0];
            mode_q  <= '0;
            hist_q  <= '1;
            vec_q   <= 3'd0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            hist_q  <= hist_d;
            vec_q   <= vec_d;
            rdata_q <= rdata_d;
        end
    end

    assign read_data_out = rdata_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus random traffic, checked by a queue-fed monitor.
module tb_int_ctrl;

    localparam logic [7:0] TB_MASK_RST = 8'h5A;

    logic        clock, reset;
    logic [7:0]  irq_n;
    logic        intCtrl, read_enable, write_enable, int_ack;
    logic [2:0]  address;
    logic [15:0] write_data_in, read_data_out;
    logic        int_req;
    logic [2:0]  int_vec;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit        req;
        bit        chkv;
        bit [2:0]  vec;
        bit [15:0] rd;
    } exp_t;
    exp_t q[$];

    // Reference state: phase 0 idle, 1 requesting, 2 in service.
    bit [7:0]  m_pend, m_mask, m_mode, m_hist;
    int        m_phase;
    bit [2:0]  m_vec;
    bit [15:0] m_rd;

    int_ctrl #(.NSRC(8), .MASK_RST(TB_MASK_RST)) dut (
        .clock         (clock),
        .reset         (reset),
        .irq_n         (irq_n),
        .intCtrl       (intCtrl),
        .read_enable   (read_enable),
        .write_enable  (write_enable),
        .address       (address),
        .write_data_in (write_data_in),
        .read_data_out (read_data_out),
        .int_req       (int_req),
        .int_ack       (int_ack),
        .int_vec       (int_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [2:0] lowest(input bit [7:0] v);
        bit [2:0] r = 3'd0;
        bit found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                r = i[2:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic m_reset();
        m_pend  = 8'h00;
        m_mask  = TB_MASK_RST;
        m_mode  = 8'h00;
        m_hist  = 8'hFF;
        m_phase = 0;
        m_vec   = 3'd0;
        m_rd    = 16'h0000;
        q.delete();
    endtask

    // One clock of the reference behaviour, using the inputs seen at this edge.
    task automatic m_step();
        bit [7:0] line   = irq_n;
        bit       cs     = intCtrl;
        bit       re     = read_enable;
        bit       we     = write_enable;
        bit       ack    = int_ack;
        bit [2:0] ad     = address;
        bit [15:0] wd    = write_data_in;
        bit [7:0] masked = m_pend & m_mask;
        bit [2:0] top    = lowest(masked);
        bit       wr     = cs && we && !re;
        bit [7:0] clr    = 8'h00;
        int       nph    = m_phase;
        exp_t     e;
        if (cs && re) begin
            case (ad)
                3'd0: m_rd = {8'h00, m_pend};
                3'd2: m_rd = {8'h00, m_mask};
                3'd4: m_rd = {8'h00, m_mode};
                3'd6: m_rd = {m_phase == 2, m_phase == 1, 11'd0, (m_phase == 1) ? top : m_vec};
                default: m_rd = 16'h0000;
            endcase
        end
        if (m_phase == 0) begin
            if (masked != 0) nph = 1;
        end else if (m_phase == 1) begin
            if (masked == 0) nph = 0;
            else if (ack) begin
                nph   = 2;
                m_vec = top;
                if (m_mode[top]) clr[top] = 1'b1;
            end
        end else begin
            if (wr && ad == 3'd6) nph = 0;
        end
        if (wr && ad == 3'd0) clr = clr | wd[7:0];
        for (int i = 0; i < 8; i++) begin
            if (!m_mode[i]) m_pend[i] = !line[i];
            else m_pend[i] = (m_hist[i] && !line[i]) || (m_pend[i] && !clr[i]);
        end
        m_hist = line;
        if (wr && ad == 3'd2) m_mask = wd[7:0];
        if (wr && ad == 3'd4) m_mode = wd[7:0];
        m_phase = nph;
        e.req  = (m_phase == 1);
        e.chkv = (m_phase != 0);
        e.vec  = (m_phase == 1) ? lowest(m_pend & m_mask) : m_vec;
        e.rd   = m_rd;
        q.push_back(e);
    endtask

    // Reference model: advances on every clock while out of reset.
    initial begin
        m_reset();
        forever begin
            @(posedge clock);
            if (reset === 1'b1) m_step();
        end
    end

    // Reset wipes the reference model and anything still queued.
    initial forever begin
        @(negedge reset);
        m_reset();
    end

    // Monitor: compares DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mon_int_req", 16'(int_req), 16'(e.req));
                if (e.chkv) chk("mon_int_vec", 16'(int_vec), 16'(e.vec));
                chk("mon_rdata", read_data_out, e.rd);
            end
        end
    end

    task automatic bus(input bit r, input bit w, input logic [2:0] a, input logic [15:0] d);
        intCtrl = 1'b1; read_enable = r; write_enable = w; address = a; write_data_in = d;
        @(negedge clock);
        intCtrl = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b0; irq_n = 8'hFF; intCtrl = 1'b0; read_enable = 1'b0;
        write_enable = 1'b0; address = 3'd0; write_data_in = 16'h0; int_ack = 1'b0;
        #3;
        chk("rst_int_req", 16'(int_req), 16'h0);
        chk("rst_int_vec", 16'(int_vec), 16'h0);
        chk("rst_rdata", read_data_out, 16'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bus(1, 0, 3'd2, 16'h0);
        chk("rst_mask", read_data_out, 16'(TB_MASK_RST));

        // Edge source 1: request appears one edge after the pending bit.
        bus(0, 1, 3'd2, 16'h0003);
        bus(0, 1, 3'd4, 16'h0003);
        irq_n[1] = 1'b0;
        @(negedge clock);
        irq_n[1] = 1'b1;
        intCtrl = 1'b1; read_enable = 1'b1; address = 3'd0;
        @(negedge clock);
        intCtrl = 1'b0; read_enable = 1'b0;
        chk("edge_pend", read_data_out, 16'h0002);
        chk("edge_req", 16'(int_req), 16'h1);
        chk("edge_vec", 16'(int_vec), 16'h1);
        int_ack = 1'b1;
        @(negedge clock);
        int_ack = 1'b0;
        chk("svc_no_req", 16'(int_req), 16'h0);
        bus(0, 1, 3'd6, 16'h0);

        // Sources 3 and 5 together: priority, ack clear, ISR, end of interrupt.
        bus(0, 1, 3'd2, 16'h00FF);
        bus(0, 1, 3'd4, 16'h00FF);
        irq_n = ~8'h28;
        @(negedge clock);
        irq_n = 8'hFF;
        @(negedge clock);
        chk("prio_req", 16'(int_req), 16'h1);
        chk("prio_vec", 16'(int_vec), 16'h3);
        int_ack = 1'b1;
        @(negedge clock);
        int_ack = 1'b0;
        bus(1, 0, 3'd0, 16'h0);
        chk("ack_pend", read_data_out, 16'h0020);
        bus(1, 0, 3'd6, 16'h0);
        chk("isr_read", read_data_out, 16'h8003);
        bus(0, 1, 3'd6, 16'h0);
        chk("eoi_idle", 16'(int_req), 16'h0);
        @(negedge clock);
        chk("next_req", 16'(int_req), 16'h1);
        chk("next_vec", 16'(int_vec), 16'h5);
        int_ack = 1'b1;
        @(negedge clock);
        int_ack = 1'b0;
        bus(0, 1, 3'd6, 16'h0);

        // Level source 2 released before ack.
        bus(0, 1, 3'd4, 16'h0000);
        bus(0, 1, 3'd2, 16'h0004);
        irq_n[2] = 1'b0;
        repeat (2) @(negedge clock);
        chk("lvl_req", 16'(int_req), 16'h1);
        chk("lvl_vec", 16'(int_vec), 16'h2);
        irq_n[2] = 1'b1;
        repeat (2) @(negedge clock);
        chk("lvl_drop", 16'(int_req), 16'h0);

        // Edge on source 0 and W1C of the same bit in one cycle: set wins.
        bus(0, 1, 3'd4, 16'h0001);
        bus(0, 1, 3'd2, 16'h0000);
        irq_n[0] = 1'b0;
        bus(0, 1, 3'd0, 16'h0001);
        irq_n[0] = 1'b1;
        bus(1, 0, 3'd0, 16'h0);
        chk("setwins_pend", read_data_out, 16'h0001);
        bus(0, 1, 3'd0, 16'h0001);
        bus(1, 0, 3'd0, 16'h0);
        chk("w1c_pend", read_data_out, 16'h0000);

        // Reset in the middle of service.
        bus(0, 1, 3'd2, 16'h0001);
        irq_n[0] = 1'b0;
        @(negedge clock);
        irq_n[0] = 1'b1;
        @(negedge clock);
        int_ack = 1'b1;
        @(negedge clock);
        int_ack = 1'b0;
        bus(1, 0, 3'd6, 16'h0);
        chk("svc_isr", read_data_out, 16'h8000);
        #2 reset = 1'b0;
        #1;
        chk("abort_req", 16'(int_req), 16'h0);
        chk("abort_rdata", read_data_out, 16'h0);
        chk("abort_vec", 16'(int_vec), 16'h0);
        @(negedge clock);
        reset = 1'b1;
        bus(1, 0, 3'd2, 16'h0);
        chk("abort_mask", read_data_out, 16'(TB_MASK_RST));
        bus(1, 0, 3'd0, 16'h0);
        chk("abort_pend", read_data_out, 16'h0);
        bus(1, 0, 3'd6, 16'h0);
        chk("abort_isr", read_data_out, 16'h0);

        // Random traffic against the reference model.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) irq_n = irq_n ^ (8'h01 << $urandom_range(0, 7));
            int_ack = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: begin intCtrl = 1'b1; read_enable = 1'b1; write_enable = 1'b0; end
                1: begin intCtrl = 1'b1; read_enable = 1'b0; write_enable = 1'b1; end
                2: begin intCtrl = 1'b1; read_enable = 1'b1; write_enable = 1'b1; end
                default: begin intCtrl = ($urandom_range(0, 1) == 1); read_enable = 1'b0; write_enable = 1'b0; end
            endcase
            address = 3'($urandom_range(0, 7));
            write_data_in = 16'($urandom);
            @(negedge clock);
        end
        intCtrl = 1'b0; read_enable = 1'b0; write_enable = 1'b0; int_ack = 1'b0;
        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
